// File: rtl/mips_datapath_pkg.sv
// Shared constants for the MIPS-32 datapath: ALU operation codes, register count
// and instruction field positions.
package datapath_pkg;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam int unsigned REG_COUNT = 32;
   localparam int unsigned REG_AW    = 5;

   localparam int unsigned RS_LSB  = 21;
   localparam int unsigned RT_LSB  = 16;
   localparam int unsigned RD_LSB  = 11;
   localparam int unsigned IMM_W   = 16;
endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory, combinational gated read and write on rising clk.
// Contents are deliberately untouched by reset.
module data_memory #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic                         clk,
   input  logic                         mem_read,
   input  logic                         mem_write,
   input  logic [$clog2(MEM_DEPTH)-1:0] addr,
   input  logic [DATA_W-1:0]            write_data,
   output logic [DATA_W-1:0]            read_data
);
   logic [DATA_W-1:0] memory [0:MEM_DEPTH-1];

   always_ff @(posedge clk) begin
      if (mem_write) memory[addr] <= write_data;
   end

   assign read_data = mem_read ? memory[addr] : '0;
endmodule

// File: rtl/register_file.sv
// 32 x 32 register file: two combinational read ports, one write port, r0 hard-wired to zero.
// Synchronous active-low reset clears every register and overrides any pending write.
module register_file
   import datapath_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_write,
   input  logic              reg_dst,
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] rt,
   input  logic [REG_AW-1:0] rd,
   input  logic [31:0]       wb_data,
   output logic [31:0]       rs_data,
   output logic [31:0]       rt_data
);
   logic [31:0]       data [0:REG_COUNT-1];
   logic [REG_AW-1:0] write_register;

   assign write_register = reg_dst ? rd : rt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < REG_COUNT; i++) data[i] <= '0;
      end else if (reg_write && (write_register != '0)) begin
         data[write_register] <= wb_data;
      end
   end

   // r0 is forced on the read side so it is zero even before the first reset
   assign rs_data = (rs == '0) ? '0 : data[rs];
   assign rt_data = (rt == '0) ? '0 : data[rt];
endmodule

// File: rtl/mips_datapath.sv
// Single-cycle MIPS-32 datapath: register file, sign extender, ALU and data memory.
// Define DATAPATH_EXT_ALU_EN to add SLT (0111) and NOR (1100) to the ALU.
module mips_datapath
   import datapath_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instruction,
   input  logic              ALUScr,
   input  logic              RegWrite,
   input  logic              RegDst,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              MemtoReg,
   input  logic [3:0]        ALUControl,
   output logic [DATA_W-1:0] ALUResult,
   output logic [DATA_W-1:0] out32,
   output logic              Zero,
   output logic [DATA_W-1:0] read_data
);
   localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);

   logic [REG_AW-1:0] rs, rt, rd;
   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] rs_data, rt_data, alu_b, wb_data;
   logic              unused_opcode;

   assign rs  = instruction[RS_LSB +: REG_AW];
   assign rt  = instruction[RT_LSB +: REG_AW];
   assign rd  = instruction[RD_LSB +: REG_AW];
   assign imm = instruction[IMM_W-1:0];
   assign unused_opcode = ^instruction[31:26];

   assign out32   = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   assign alu_b   = ALUScr ? out32 : rt_data;
   assign wb_data = MemtoReg ? read_data : ALUResult;

   always_comb begin
      ALUResult = '0;
      case (ALUControl)
         ALU_AND: ALUResult = rs_data & alu_b;
         ALU_OR:  ALUResult = rs_data | alu_b;
         ALU_ADD: ALUResult = rs_data + alu_b;
         ALU_SUB: ALUResult = rs_data - alu_b;
`ifdef DATAPATH_EXT_ALU_EN
         ALU_SLT: ALUResult = ($signed(rs_data) < $signed(alu_b)) ? DATA_W'(1) : '0;
         ALU_NOR: ALUResult = ~(rs_data | alu_b);
`endif
         default: ALUResult = '0;
      endcase
   end

   assign Zero = (ALUResult == '0);

   register_file registers_inst (
      .clk       (clk),
      .rst       (rst),
      .reg_write (RegWrite),
      .reg_dst   (RegDst),
      .rs        (rs),
      .rt        (rt),
      .rd        (rd),
      .wb_data   (wb_data),
      .rs_data   (rs_data),
      .rt_data   (rt_data)
   );

   data_memory #(
      .DATA_W    (DATA_W),
      .MEM_DEPTH (MEM_DEPTH)
   ) data_memory_inst (
      .clk        (clk),
      .mem_read   (MemRead),
      .mem_write  (MemWrite),
      .addr       (ALUResult[ADDR_W-1:0]),
      .write_data (rt_data),
      .read_data  (read_data)
   );
endmodule

// File: tb/tb_mips_datapath.sv
// Directed self-checking bench for mips_datapath: load/store, R-type, branch compare,
// reset behaviour, r0 handling, sign extension and the optional extended ALU ops.
module tb_mips_datapath;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instruction;
   logic        ALUScr, RegWrite, RegDst, MemRead, MemWrite, MemtoReg;
   logic [3:0]  ALUControl;
   logic [31:0] ALUResult, out32, read_data;
   logic        Zero;

   int checks = 0;
   int errors = 0;

   mips_datapath #(.DATA_W(32), .MEM_DEPTH(256)) dut (
      .clk         (clk),
      .rst         (rst),
      .instruction (instruction),
      .ALUScr      (ALUScr),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .MemtoReg    (MemtoReg),
      .ALUControl  (ALUControl),
      .ALUResult   (ALUResult),
      .out32       (out32),
      .Zero        (Zero),
      .read_data   (read_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // drive one instruction with its control word, then let combinational paths settle
   task automatic drive(input logic [31:0] ins, input logic scr, input logic rw, input logic dst,
                        input logic mr, input logic mw, input logic m2r, input logic [3:0] ctl);
      instruction = ins; ALUScr = scr; RegWrite = rw; RegDst = dst;
      MemRead = mr; MemWrite = mw; MemtoReg = m2r; ALUControl = ctl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      drive(32'h0, 0, 0, 0, 0, 0, 0, 4'b0000);
      tick();
      tick();
      check("reset_alu",   ALUResult, 32'h0);
      check("reset_out32", out32,     32'h0);
      check("reset_zero",  {31'h0, Zero}, 32'h1);
      check("reset_rdata", read_data, 32'h0);
      for (int i = 0; i < 32; i++) check("reset_reg", dut.registers_inst.data[i], 32'h0);
      rst = 1'b1;

      // preload r17=4, r18=2, mem[5]=0xA through the datapath itself
      drive(32'h20110004, 1, 1, 0, 0, 0, 0, 4'b0010); tick();
      drive(32'h20120002, 1, 1, 0, 0, 0, 0, 4'b0010); tick();
      drive(32'h2001000A, 1, 1, 0, 0, 0, 0, 4'b0010); tick();
      drive(32'hAC010005, 1, 0, 0, 0, 1, 0, 4'b0010); tick();
      drive(32'h20010000, 1, 1, 0, 0, 0, 0, 4'b0010); tick();
      check("pre_r17",  dut.registers_inst.data[17], 32'h4);
      check("pre_r18",  dut.registers_inst.data[18], 32'h2);
      check("pre_mem5", dut.data_memory_inst.memory[5], 32'hA);

      // LW r8, 5(r0)
      drive(32'h8C080005, 1, 1, 0, 1, 0, 1, 4'b0010);
      check("lw_addr",  ALUResult, 32'h5);
      check("lw_rdata", read_data, 32'hA);
      tick();
      check("lw_r8", dut.registers_inst.data[8], 32'hA);

      // ADD r9 = r17 + r18
      drive(32'h02324820, 0, 1, 1, 0, 0, 0, 4'b0010);
      check("add_wreg", 32'(dut.registers_inst.write_register), 32'd9);
      check("add_alu",  ALUResult, 32'h6);
      tick();
      check("add_r9", dut.registers_inst.data[9], 32'h6);

      // SUB r10 = r17 - r18
      drive(32'h02325022, 0, 1, 1, 0, 0, 0, 4'b0110);
      tick();
      check("sub_r10", dut.registers_inst.data[10], 32'h2);

      // AND / OR / unsupported code on r17, r18
      drive(32'h02320000, 0, 0, 1, 0, 0, 0, 4'b0000);
      check("and_alu",  ALUResult, 32'h0);
      check("and_zero", {31'h0, Zero}, 32'h1);
      drive(32'h02320000, 0, 0, 1, 0, 0, 0, 4'b0001);
      check("or_alu", ALUResult, 32'h6);
      drive(32'h02320000, 0, 0, 1, 0, 0, 0, 4'b0011);
      check("bad_code", ALUResult, 32'h0);

      // MemRead low gates read_data even at a populated address
      drive(32'h8C080005, 1, 0, 0, 0, 0, 0, 4'b0010);
      check("rd_gated", read_data, 32'h0);

      // SW r9, 10(r0)
      drive(32'hAC09000A, 1, 0, 0, 0, 1, 0, 4'b0010);
      check("sw_wdata", dut.data_memory_inst.write_data, 32'h6);
      tick();
      check("sw_mem10", dut.data_memory_inst.memory[10], 32'h6);

      // ADD r11 = r17 + r9, then BEQ r8, r11
      drive(32'h02295820, 0, 1, 1, 0, 0, 0, 4'b0010);
      tick();
      check("add_r11", dut.registers_inst.data[11], 32'hA);
      drive(32'h110B0001, 0, 0, 0, 0, 0, 0, 4'b0110);
      check("beq_zero",  {31'h0, Zero}, 32'h1);
      check("beq_out32", out32, 32'h1);

      // read and write the same word in one cycle: old value visible, new value stored
      drive(32'hAC0B000A, 1, 0, 0, 1, 1, 0, 4'b0010);
      check("rw_old", read_data, 32'h6);
      tick();
      check("rw_new", dut.data_memory_inst.memory[10], 32'hA);

      // register write and memory write honoured together: r12 = 10, mem[10] = r12 (old 0)
      drive(32'hAC0C000A, 1, 1, 0, 0, 1, 0, 4'b0010);
      tick();
      check("dual_r12",  dut.registers_inst.data[12], 32'hA);
      check("dual_mem",  dut.data_memory_inst.memory[10], 32'h0);

      // reset clears registers; memory survives
      rst = 1'b0;
      drive(32'h02324820, 0, 1, 1, 0, 0, 0, 4'b0010);
      tick();
      rst = 1'b1;
      check("rst_r8",  dut.registers_inst.data[8],  32'h0);
      check("rst_r9",  dut.registers_inst.data[9],  32'h0);
      check("rst_r17", dut.registers_inst.data[17], 32'h0);
      drive(32'h8C080005, 1, 0, 0, 1, 0, 0, 4'b0010);
      check("mem_kept", read_data, 32'hA);

      // write to r0 is discarded
      drive(32'h20001234, 1, 1, 0, 0, 0, 0, 4'b0010);
      check("r0_alu", ALUResult, 32'h1234);
      tick();
      check("r0_data", dut.registers_inst.data[0], 32'h0);
      drive(32'h00000000, 0, 0, 0, 0, 0, 0, 4'b0010);
      check("r0_read", ALUResult, 32'h0);

      // sign extension of 0xFFFF; load r2=-1, r3=2
      drive(32'h2002FFFF, 1, 1, 0, 0, 0, 0, 4'b0010);
      check("sext_ffff", out32, 32'hFFFFFFFF);
      tick();
      drive(32'h20030002, 1, 1, 0, 0, 0, 0, 4'b0010);
      tick();
      check("neg_r2", dut.registers_inst.data[2], 32'hFFFFFFFF);

      drive(32'h00430000, 0, 0, 0, 0, 0, 0, 4'b0111);
`ifdef DATAPATH_EXT_ALU_EN
      check("slt", ALUResult, 32'h1);
`else
      check("slt", ALUResult, 32'h0);
`endif
      drive(32'h00000000, 0, 0, 0, 0, 0, 0, 4'b1100);
`ifdef DATAPATH_EXT_ALU_EN
      check("nor", ALUResult, 32'hFFFFFFFF);
`else
      check("nor", ALUResult, 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
